// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch-stage bus between the IFU, instruction memory and decode
interface instruction_fetch_unit_if #(
    parameter int N   = 16,
    parameter int eff = 10
);
    logic [N-1:0]   pc;
    logic [eff-1:0] mem_addr;
    logic [N-1:0]   instruction;
    logic           stall;
    logic           branch_taken;
    logic [N-1:0]   branch_target;
    logic [N-1:0]   if_id_instruction;
    logic [N-1:0]   if_id_pc;
    logic           if_id_valid;
    logic [15:0]    fetch_count;
    logic           halted;

    // instruction memory is word addressed by the low eff bits of the PC
    assign mem_addr = pc[eff-1:0];

    modport master (
        output pc, if_id_instruction, if_id_pc, if_id_valid, fetch_count, halted,
        input  instruction, stall, branch_taken, branch_target
    );

    modport slave (
        input  pc, mem_addr, if_id_instruction, if_id_pc, if_id_valid, fetch_count, halted,
        output instruction, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register and IF/ID pipeline register; optional HALT detection under IFU_HALT_DETECT_EN
module instruction_fetch_unit #(
    parameter int          N        = 16,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP      = '0
`ifdef IFU_HALT_DETECT_EN
    ,
    parameter logic [3:0]   HALT_OP  = 4'hF
`endif
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_unit_if.master bus
);

`ifdef IFU_HALT_DETECT_EN
    typedef enum logic {FETCH, HALTED} state_t;
    state_t state;
    logic   hit;
    assign hit = bus.instruction[N-1:N-4] == HALT_OP;
`else
    assign bus.halted = 1'b0;
`endif

    // priority rst > redirect > stall > halted > fetch; PC is a pure register
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pc                <= RESET_PC;
            bus.if_id_instruction <= NOP;
            bus.if_id_pc          <= '0;
            bus.if_id_valid       <= 1'b0;
            bus.fetch_count       <= '0;
`ifdef IFU_HALT_DETECT_EN
            state                 <= FETCH;
            bus.halted            <= 1'b0;
`endif
        end else if (bus.branch_taken) begin
            bus.pc                <= bus.branch_target;
            bus.if_id_instruction <= NOP;
            bus.if_id_valid       <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
            state                 <= FETCH;
            bus.halted            <= 1'b0;
`endif
        end else if (!bus.stall) begin
`ifdef IFU_HALT_DETECT_EN
            if (state == HALTED) begin
                bus.if_id_instruction <= NOP;
                bus.if_id_valid       <= 1'b0;
            end else begin
                bus.if_id_instruction <= bus.instruction;
                bus.if_id_pc          <= bus.pc;
                bus.if_id_valid       <= 1'b1;
                bus.fetch_count       <= bus.fetch_count + 16'd1;
                bus.pc                <= hit ? bus.pc : bus.pc + 1'b1;
                state                 <= hit ? HALTED : FETCH;
                bus.halted            <= hit;
            end
`else
            bus.if_id_instruction <= bus.instruction;
            bus.if_id_pc          <= bus.pc;
            bus.if_id_valid       <= 1'b1;
            bus.fetch_count       <= bus.fetch_count + 16'd1;
            bus.pc                <= bus.pc + 1'b1;
`endif
        end
    end

endmodule
